// File: rtl/iso14443a_frame_decode.sv
// rtl/iso14443a_frame_decode.sv - ISO14443A PCD frame decoder from X/Y/Z bit sequences
//
// Purpose:
//   Turns the stream of modified-Miller bit sequences (X, Y, Z, ERROR) from the
//   sequence decoder into frame events: start/end of frame, received bytes
//   (odd parity checked) or a trailing partial byte, and error flags.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   sd_seq[1:0]    in   sequence code: 0=X, 1=Y, 2=Z, 3=ERROR
//   sd_seq_valid   in   single-cycle strobe qualifying sd_seq
//   soc            out  one-cycle start-of-frame pulse
//   eoc            out  one-cycle end-of-frame pulse
//   data[7:0]      out  received byte / partial byte, LSb = first bit
//   data_bits[2:0] out  valid bits in data, 0 means 8
//   data_valid     out  one-cycle pulse qualifying data/data_bits
//   sequence_error out  one-cycle pulse on an illegal sequence
//   parity_error   out  one-cycle pulse on a bad or missing parity bit

module iso14443a_frame_decode (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sd_seq,
  input  logic       sd_seq_valid,
  output logic       soc,
  output logic       eoc,
  output logic [7:0] data,
  output logic [2:0] data_bits,
  output logic       data_valid,
  output logic       sequence_error,
  output logic       parity_error
);

  localparam logic [1:0] SEQ_X     = 2'd0;
  localparam logic [1:0] SEQ_Y     = 2'd1;
  localparam logic [1:0] SEQ_Z     = 2'd2;
  localparam logic [1:0] SEQ_ERROR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t     r_state;
  // Last accepted sequence was a logic 0 (Z or Y) or the SOC.
  logic       r_prev_zero;
  logic       r_pend_valid;
  logic       r_pend_bit;
  logic       r_byte_done;
  logic [3:0] r_count;
  logic [7:0] r_shift;

  logic       r_soc;
  logic       r_eoc;
  logic [7:0] r_data;
  logic [2:0] r_data_bits;
  logic       r_data_valid;
  logic       r_sequence_error;
  logic       r_parity_error;

  logic       w_is_eoc;
  logic       w_bad_seq;
  logic       w_new_bit;
  logic       w_parity_ok;

  // Y after a logic 0 is the end-of-frame marker.
  assign w_is_eoc    = (sd_seq == SEQ_Y) && r_prev_zero;
  // A Z directly after an X cannot occur in a legal frame.
  assign w_bad_seq   = (sd_seq == SEQ_ERROR) || ((sd_seq == SEQ_Z) && !r_prev_zero);
  assign w_new_bit   = (sd_seq == SEQ_X);
  // Odd parity: data ones plus the pending parity bit must be odd.
  assign w_parity_ok = ^{r_shift, r_pend_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_prev_zero      <= 1'b0;
      r_pend_valid     <= 1'b0;
      r_pend_bit       <= 1'b0;
      r_byte_done      <= 1'b0;
      r_count          <= 4'd0;
      r_shift          <= 8'd0;
      r_soc            <= 1'b0;
      r_eoc            <= 1'b0;
      r_data           <= 8'd0;
      r_data_bits      <= 3'd0;
      r_data_valid     <= 1'b0;
      r_sequence_error <= 1'b0;
      r_parity_error   <= 1'b0;
    end else begin
      r_soc            <= 1'b0;
      r_eoc            <= 1'b0;
      r_data_valid     <= 1'b0;
      r_sequence_error <= 1'b0;
      r_parity_error   <= 1'b0;

      if (sd_seq_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (sd_seq == SEQ_Z) begin
              r_soc        <= 1'b1;
              r_state      <= ST_RX;
              r_prev_zero  <= 1'b1;
              r_pend_valid <= 1'b0;
              r_count      <= 4'd0;
              r_shift      <= 8'd0;
              r_byte_done  <= 1'b0;
            end
          end

          ST_RX: begin
            if (w_bad_seq) begin
              r_sequence_error <= 1'b1;
              r_state          <= ST_ERR;
              r_prev_zero      <= (sd_seq == SEQ_Z);
              r_pend_valid     <= 1'b0;
            end else if (w_is_eoc) begin
              // The pending 0 is part of the EOC pattern and is dropped.
              r_eoc        <= 1'b1;
              r_state      <= ST_IDLE;
              r_pend_valid <= 1'b0;
              r_prev_zero  <= 1'b0;
              if (r_count == 4'd0) begin
                if (!r_byte_done) begin
                  r_sequence_error <= 1'b1;
                end
              end else if (r_count == 4'd8) begin
                r_parity_error <= 1'b1;
              end else begin
                r_data_valid <= 1'b1;
                r_data       <= r_shift;
                r_data_bits  <= r_count[2:0];
              end
            end else begin
              // Legal data sequence: commit the previous bit, hold the new one.
              r_prev_zero  <= (sd_seq != SEQ_X);
              r_pend_valid <= 1'b1;
              r_pend_bit   <= w_new_bit;
              if (r_pend_valid) begin
                if (r_count == 4'd8) begin
                  if (w_parity_ok) begin
                    r_data_valid <= 1'b1;
                    r_data       <= r_shift;
                    r_data_bits  <= 3'd0;
                    r_count      <= 4'd0;
                    r_shift      <= 8'd0;
                    r_byte_done  <= 1'b1;
                  end else begin
                    r_parity_error <= 1'b1;
                    r_state        <= ST_ERR;
                    r_pend_valid   <= 1'b0;
                  end
                end else begin
                  r_shift[r_count[2:0]] <= r_pend_bit;
                  r_count               <= r_count + 4'd1;
                end
              end
            end
          end

          ST_ERR: begin
            if (w_is_eoc) begin
              r_eoc       <= 1'b1;
              r_state     <= ST_IDLE;
              r_prev_zero <= 1'b0;
            end else begin
              r_prev_zero <= (sd_seq == SEQ_Y) || (sd_seq == SEQ_Z);
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign soc            = r_soc;
  assign eoc            = r_eoc;
  assign data           = r_data;
  assign data_bits      = r_data_bits;
  assign data_valid     = r_data_valid;
  assign sequence_error = r_sequence_error;
  assign parity_error   = r_parity_error;

endmodule

// File: tb/tb_iso14443a_frame_decode.sv
// tb/tb_iso14443a_frame_decode.sv - scoreboard bench for iso14443a_frame_decode

module tb_iso14443a_frame_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sd_seq;
  logic       sd_seq_valid;
  logic       soc;
  logic       eoc;
  logic [7:0] data;
  logic [2:0] data_bits;
  logic       data_valid;
  logic       sequence_error;
  logic       parity_error;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       soc;
    logic       eoc;
    logic       dv;
    logic [7:0] data;
    logic [2:0] bits;
    logic       se;
    logic       pe;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;

  always #5 clk = ~clk;

  iso14443a_frame_decode dut (
    .clk            (clk),
    .rst            (rst),
    .sd_seq         (sd_seq),
    .sd_seq_valid   (sd_seq_valid),
    .soc            (soc),
    .eoc            (eoc),
    .data           (data),
    .data_bits      (data_bits),
    .data_valid     (data_valid),
    .sequence_error (sequence_error),
    .parity_error   (parity_error)
  );

  task automatic push(input logic s, input logic e, input logic d, input logic [7:0] dat,
                      input logic [2:0] b, input logic se, input logic pe);
    ev_t ev;
    ev.soc  = s;
    ev.eoc  = e;
    ev.dv   = d;
    ev.data = dat;
    ev.bits = b;
    ev.se   = se;
    ev.pe   = pe;
    exp_q.push_back(ev);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Sequence presented for one cycle; junk Z on the bus while strobe is low.
  task automatic send(input logic [1:0] s, input int gap);
    sd_seq       = s;
    sd_seq_valid = 1'b1;
    @(posedge clk); #1;
    sd_seq_valid = 1'b0;
    sd_seq       = 2'd2;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input string f);
    logic [1:0] code;
    for (int i = 0; i < f.len(); i++) begin
      case (f[i])
        "X":     code = 2'd0;
        "Y":     code = 2'd1;
        "Z":     code = 2'd2;
        default: code = 2'd3;
      endcase
      send(code, i % 2);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every output pulse pops and compares one expected event.
  always @(negedge clk) begin
    if (soc || eoc || data_valid || sequence_error || parity_error) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: soc=%b eoc=%b dv=%b se=%b pe=%b data=0x%0h bits=%0d",
                 soc, eoc, data_valid, sequence_error, parity_error, data, data_bits);
      end else begin
        mon_ev = exp_q.pop_front();
        if ({soc, eoc, data_valid, sequence_error, parity_error} !==
              {mon_ev.soc, mon_ev.eoc, mon_ev.dv, mon_ev.se, mon_ev.pe} ||
            (mon_ev.dv && (data !== mon_ev.data || data_bits !== mon_ev.bits))) begin
          errors++;
          $display("FAIL event: got soc=%b eoc=%b dv=%b se=%b pe=%b data=0x%0h bits=%0d, expected soc=%b eoc=%b dv=%b se=%b pe=%b data=0x%0h bits=%0d",
                   soc, eoc, data_valid, sequence_error, parity_error, data, data_bits,
                   mon_ev.soc, mon_ev.eoc, mon_ev.dv, mon_ev.se, mon_ev.pe, mon_ev.data, mon_ev.bits);
        end
      end
    end
  end

  initial begin
    string base;
    string f;

    rst          = 1'b1;
    sd_seq       = 2'd0;
    sd_seq_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_soc", {31'd0, soc}, 32'd0);
    check("reset_eoc", {31'd0, eoc}, 32'd0);
    check("reset_dv", {31'd0, data_valid}, 32'd0);
    check("reset_flags", {30'd0, sequence_error, parity_error}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_bits", {29'd0, data_bits}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle garbage is ignored.
    send_frame("XYEYX");

    // Single byte 0x29, parity 0 (Z).
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 0, 1, 8'h29, 3'd0, 0, 0);
    push(0, 1, 0, 8'h00, 3'd0, 0, 0);
    send_frame("ZXYZXYXYZZZY");

    // Same byte with wrong parity (X).
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 0, 0, 8'h00, 3'd0, 0, 1);
    push(0, 1, 0, 8'h00, 3'd0, 0, 0);
    send_frame("ZXYZXYXYZXYY");

    // Byte without parity bit.
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 1, 0, 8'h00, 3'd0, 0, 1);
    send_frame("ZXYZXYXYZZY");

    // Empty frames.
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 1, 0, 8'h00, 3'd0, 1, 0);
    send_frame("ZZY");
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 1, 0, 8'h00, 3'd0, 1, 0);
    send_frame("ZYY");

    // Three-bit frame 1,0,1.
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 1, 1, 8'h05, 3'd3, 0, 0);
    send_frame("ZXYXYY");
    check("hold_data", {24'd0, data}, 32'h05);
    check("hold_bits", {29'd0, data_bits}, 32'd3);

    // Byte 0x03 with parity 1 (X).
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 0, 1, 8'h03, 3'd0, 0, 0);
    push(0, 1, 0, 8'h00, 3'd0, 0, 0);
    send_frame("ZXXYZZZZZXYY");

    // Full byte followed by a 3-bit partial byte.
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 0, 1, 8'h29, 3'd0, 0, 0);
    push(0, 1, 1, 8'h05, 3'd3, 0, 0);
    send_frame("ZXYZXYXYZZXYXYY");

    // ERROR injected at each of positions 1..9.
    base = "XYZXYXYZZ";
    for (int k = 0; k < 9; k++) begin
      f = base;
      f.putc(k, "E");
      push(1, 0, 0, 8'h00, 3'd0, 0, 0);
      push(0, 0, 0, 8'h00, 3'd0, 1, 0);
      push(0, 1, 0, 8'h00, 3'd0, 0, 0);
      send_frame({"Z", f, "ZY"});
    end

    // Reset in the middle of a frame aborts it silently.
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    send(2'd2, 0);
    send(2'd0, 1);
    send(2'd1, 0);
    send(2'd2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_data", {24'd0, data}, 32'd0);
    check("midreset_bits", {29'd0, data_bits}, 32'd0);
    push(1, 0, 0, 8'h00, 3'd0, 0, 0);
    push(0, 0, 1, 8'h29, 3'd0, 0, 0);
    push(0, 1, 0, 8'h00, 3'd0, 0, 0);
    send_frame("ZXYZXYXYZZZY");

    repeat (5) @(posedge clk);
    #1;
    check("events_outstanding", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
